// File: rtl/assoc_cache.sv
// Set-associative cache between the CPU datapath and a 4-word-wide memory port.
// Write-through with write-allocate, true-LRU replacement via per-way age
// counters, and saturating hit/miss counters for performance reporting.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | combinational lookup; read hits complete in the same cycle
// S_FILL  | fetch the missing line into the chosen victim way
// S_WRITE | write the updated line through to memory
// S_RESP  | one-cycle readyC completing a miss or a write
module assoc_cache #(
    parameter int WORD_SIZE = 16,
    parameter int SETS      = 4,
    parameter int WAYS      = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   readC,
    input  logic                   writeC,
    input  logic [WORD_SIZE-1:0]   address,
    inout  wire  [WORD_SIZE-1:0]   data,
    output logic                   readyC,
    output logic                   readM,
    output logic                   writeM,
    output logic [WORD_SIZE-1:0]   address_M,
    inout  wire  [4*WORD_SIZE-1:0] dataM,
    input  logic                   readyM,
    input  logic                   input_readyM,
    input  logic                   doneM,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);

    localparam int IDX_BITS = $clog2(SETS);
    localparam int IDX_W    = (SETS > 1) ? IDX_BITS : 1;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W    = WORD_SIZE - 2 - IDX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

    state_t               state_q, state_d;
    logic                 valid_q [SETS][WAYS];
    logic                 valid_d [SETS][WAYS];
    logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]     tag_d   [SETS][WAYS];
    logic [WORD_SIZE-1:0] line_q  [SETS][WAYS][4];
    logic [WORD_SIZE-1:0] line_d  [SETS][WAYS][4];
    logic [WAY_W-1:0]     age_q   [SETS][WAYS];
    logic [WAY_W-1:0]     age_d   [SETS][WAYS];
    logic [WAY_W-1:0]     way_q, way_d;
    logic                 op_wr_q, op_wr_d;
    logic                 rd_m_q, rd_m_d;
    logic                 wr_m_q, wr_m_d;
    logic [WORD_SIZE-1:0] addr_m_q, addr_m_d;
    logic [15:0]          hit_cnt_q, hit_cnt_d;
    logic [15:0]          miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [1:0]             req_off;
    logic [WORD_SIZE-1:0]   line_addr;
    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic                   vic_found;
    logic [WAY_W-1:0]       vic_way;
    logic [WAY_W-1:0]       vic_age;
    logic                   touch;
    logic [WAY_W-1:0]       touch_way;
    logic                   inc_hit, inc_miss;
    logic [WAY_W-1:0]       rd_way;
    logic [WORD_SIZE-1:0]   rd_word;
    logic [4*WORD_SIZE-1:0] wr_line;

    assign req_off   = address[1:0];
    assign req_tag   = address[WORD_SIZE-1 -: TAG_W];
    assign line_addr = {address[WORD_SIZE-1:2], 2'b00};

    generate
        if (SETS > 1) begin : g_idx
            assign req_idx = address[2 +: IDX_W];
        end else begin : g_no_idx
            assign req_idx = '0;
        end
    endgenerate

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the oldest way.
    always_comb begin
        vic_found = 1'b0;
        vic_way   = '0;
        vic_age   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[req_idx][w]) begin
                vic_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] >= vic_age) begin
                    vic_age = age_q[req_idx][w];
                    vic_way = WAY_W'(w);
                end
            end
        end
    end

    // Next-state, line updates, LRU aging and counters.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        line_d    = line_q;
        age_d     = age_q;
        way_d     = way_q;
        op_wr_d   = op_wr_q;
        rd_m_d    = rd_m_q;
        wr_m_d    = wr_m_q;
        addr_m_d  = addr_m_q;
        readyC    = 1'b0;
        inc_hit   = 1'b0;
        inc_miss  = 1'b0;
        touch     = 1'b0;
        touch_way = way_q;

        case (state_q)
            S_IDLE: begin
                // A simultaneous read and write is handled as a write.
                if (writeC) begin
                    op_wr_d = 1'b1;
                    if (hit) begin
                        line_d[req_idx][hit_way][req_off] = data;
                        inc_hit   = 1'b1;
                        touch     = 1'b1;
                        touch_way = hit_way;
                        way_d     = hit_way;
                        state_d   = S_WRITE;
                    end else begin
                        inc_miss = 1'b1;
                        way_d    = vic_way;
                        state_d  = S_FILL;
                    end
                end else if (readC) begin
                    op_wr_d = 1'b0;
                    if (hit) begin
                        readyC    = 1'b1;
                        inc_hit   = 1'b1;
                        touch     = 1'b1;
                        touch_way = hit_way;
                    end else begin
                        inc_miss = 1'b1;
                        way_d    = vic_way;
                        state_d  = S_FILL;
                    end
                end
            end
            S_FILL: begin
                // readyM only counts once our request is actually on the bus.
                if (rd_m_q) begin
                    if (readyM) begin
                        rd_m_d                   = 1'b0;
                        valid_d[req_idx][way_q]  = 1'b1;
                        tag_d[req_idx][way_q]    = req_tag;
                        for (int k = 0; k < 4; k++) begin
                            line_d[req_idx][way_q][k] = dataM[k*WORD_SIZE +: WORD_SIZE];
                        end
                        touch     = 1'b1;
                        touch_way = way_q;
                        if (op_wr_q) begin
                            line_d[req_idx][way_q][req_off] = data;
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_RESP;
                        end
                    end
                end else if (input_readyM) begin
                    rd_m_d   = 1'b1;
                    addr_m_d = line_addr;
                end
            end
            S_WRITE: begin
                if (wr_m_q) begin
                    if (doneM) begin
                        wr_m_d  = 1'b0;
                        state_d = S_RESP;
                    end
                end else if (input_readyM) begin
                    wr_m_d   = 1'b1;
                    addr_m_d = line_addr;
                end
            end
            S_RESP: begin
                readyC  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Accessed way becomes youngest; valid ways younger than it age by one.
        if (touch && (WAYS > 1)) begin
            for (int w = 0; w < WAYS; w++) begin
                if (valid_q[req_idx][w] && (age_q[req_idx][w] < age_q[req_idx][touch_way])) begin
                    age_d[req_idx][w] = age_q[req_idx][w] + 1'b1;
                end
            end
            age_d[req_idx][touch_way] = '0;
        end

        hit_cnt_d  = (inc_hit  && (hit_cnt_q  != 16'hFFFF)) ? hit_cnt_q  + 16'd1 : hit_cnt_q;
        miss_cnt_d = (inc_miss && (miss_cnt_q != 16'hFFFF)) ? miss_cnt_q + 16'd1 : miss_cnt_q;
    end

    // Read word mux for the CPU and line image for memory writes.
    always_comb begin
        rd_way  = (state_q == S_RESP) ? way_q : hit_way;
        rd_word = line_q[req_idx][rd_way][req_off];
        wr_line = '0;
        for (int k = 0; k < 4; k++) begin
            wr_line[k*WORD_SIZE +: WORD_SIZE] = line_q[req_idx][way_q][k];
        end
    end

    assign data  = (readC && !writeC && readyC) ? rd_word : 'z;
    assign dataM = wr_m_q ? wr_line : 'z;

    assign readM      = rd_m_q;
    assign writeM     = wr_m_q;
    assign address_M  = addr_m_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // State registers; reset abandons any memory transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            way_q      <= '0;
            op_wr_q    <= 1'b0;
            rd_m_q     <= 1'b0;
            wr_m_q     <= 1'b0;
            addr_m_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= WAY_W'(w);
                    for (int k = 0; k < 4; k++) begin
                        line_q[s][w][k] <= '0;
                    end
                end
            end
        end else begin
            state_q    <= state_d;
            way_q      <= way_d;
            op_wr_q    <= op_wr_d;
            rd_m_q     <= rd_m_d;
            wr_m_q     <= wr_m_d;
            addr_m_q   <= addr_m_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            age_q      <= age_d;
            line_q     <= line_d;
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed scenarios plus random traffic, checked by a
// scoreboard fed from an LRU list model and a reference memory image.
module tb_assoc_cache;

    localparam int SETS = 4;
    localparam int WAYS = 2;
    localparam int MEMW = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        readC = 1'b0;
    logic        writeC = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] cpu_dout = '0;
    logic        cpu_drive = 1'b0;
    wire  [15:0] data;
    wire  [63:0] dataM;
    logic        readyC, readM, writeM;
    logic [15:0] address_M, hit_count, miss_count;
    logic        readyM = 1'b0;
    logic        doneM = 1'b0;
    logic        input_readyM;
    logic        block = 1'b0;
    logic        mem_busy = 1'b0;
    logic [63:0] mem_dout = '0;
    logic        mem_drive = 1'b0;
    int          fixed_lat = 0;

    assign data         = cpu_drive ? cpu_dout : 'z;
    assign dataM        = mem_drive ? mem_dout : 'z;
    assign input_readyM = !block && !mem_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ref_mem [MEMW];
    logic [15:0] mem_arr [MEMW];
    logic [15:0] cur_addr = '0;

    // Reference model: per set, tags in most-recently-used-first order.
    int m_tag [SETS][WAYS];
    int m_n   [SETS];
    int m_hits   = 0;
    int m_misses = 0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        bit          hit;
        int          hits;
        int          misses;
    } exp_t;
    exp_t sb_q[$];

    assoc_cache #(.WORD_SIZE(16), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .readC        (readC),
        .writeC       (writeC),
        .address      (address),
        .data         (data),
        .readyC       (readyC),
        .readM        (readM),
        .writeM       (writeM),
        .address_M    (address_M),
        .dataM        (dataM),
        .readyM       (readyM),
        .input_readyM (input_readyM),
        .doneM        (doneM),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) m_n[s] = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic bit model_access(input logic [15:0] a);
        int s, t, p;
        bit h;
        s = (int'(a) >> 2) % SETS;
        t = int'(a) >> (2 + $clog2(SETS));
        p = -1;
        for (int i = 0; i < m_n[s]; i++) if (m_tag[s][i] == t) p = i;
        h = (p >= 0);
        if (!h) begin
            if (m_n[s] < WAYS) m_n[s]++;
            p = m_n[s] - 1;
        end
        for (int i = p; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
        m_tag[s][0] = t;
        return h;
    endfunction

    // CPU driver: predicts the outcome, queues it, then runs the handshake.
    task automatic do_req(input bit wr, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        bit   h;
        int   t;
        h = model_access(a);
        if (h) m_hits++; else m_misses++;
        if (wr) ref_mem[a[7:0]] = d;
        e.wr = wr; e.addr = a; e.data = ref_mem[a[7:0]]; e.hit = h;
        e.hits = m_hits; e.misses = m_misses;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cur_addr  = a;
        address   = a;
        readC     = !wr;
        writeC    = wr;
        cpu_dout  = d;
        cpu_drive = wr;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!readyC && t < 200);
        if (!readyC) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: addr %h got no readyC, required within 200 cycles", a);
            sb_q.delete();
        end
        @(posedge clk); #1;
        readC     = 1'b0;
        writeC    = 1'b0;
        cpu_drive = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every readyC and checks data, latency class, counters.
    initial begin : monitor
        int   wait_c;
        bit   cnt_pend;
        exp_t e;
        exp_t pend;
        wait_c   = 0;
        cnt_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                wait_c   = 0;
                cnt_pend = 1'b0;
                continue;
            end
            check("mem_rd_wr_excl", {63'd0, readM & writeM}, 64'd0);
            if (cnt_pend) begin
                check("hit_count", hit_count, pend.hits);
                check("miss_count", miss_count, pend.misses);
                cnt_pend = 1'b0;
            end
            if (readyC) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_readyC: got readyC=1 with no request outstanding, required 0");
                end else begin
                    e = sb_q.pop_front();
                    if (!e.wr) check("rd_data", data, e.data);
                    if (!e.wr && e.hit) check("hit_latency", wait_c, 0);
                    else                check("miss_or_write_latency", {63'd0, wait_c > 0}, 64'd1);
                    pend     = e;
                    cnt_pend = 1'b1;
                end
                wait_c = 0;
            end else if (readC || writeC) begin
                wait_c++;
            end
        end
    end

    // Memory model: answers line reads from its array, commits line writes.
    initial begin : mem_responder
        int          la, lat;
        logic [63:0] line;
        logic [63:0] wline;
        forever begin
            @(negedge clk);
            readyM    = 1'b0;
            doneM     = 1'b0;
            mem_drive = 1'b0;
            if (reset_n && readM) begin
                check("rd_address_M", address_M, {cur_addr[15:2], 2'b00});
                la       = int'(address_M[7:0]);
                mem_busy = 1'b1;
                lat      = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                repeat (lat) @(negedge clk);
                for (int k = 0; k < 4; k++) line[k*16 +: 16] = mem_arr[la+k];
                mem_dout  = line;
                mem_drive = 1'b1;
                readyM    = 1'b1;
                mem_busy  = 1'b0;
            end else if (reset_n && writeM) begin
                check("wr_address_M", address_M, {cur_addr[15:2], 2'b00});
                la = int'(address_M[7:0]);
                for (int k = 0; k < 4; k++) line[k*16 +: 16] = ref_mem[la+k];
                check("wr_line", dataM, line);
                wline    = dataM;
                mem_busy = 1'b1;
                lat      = int'($urandom_range(1, 4));
                repeat (lat) @(negedge clk);
                for (int k = 0; k < 4; k++) mem_arr[la+k] = wline[k*16 +: 16];
                doneM    = 1'b1;
                mem_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        logic [15:0] a, d, v;
        bit          wr;
        int          t;
        for (int i = 0; i < MEMW; i++) begin
            v = 16'(i);
            v = (v * 16'd257) ^ 16'h5A5A;
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        mem_arr[16'h10] = 16'h1111; ref_mem[16'h10] = 16'h1111;
        mem_arr[16'h11] = 16'h2222; ref_mem[16'h11] = 16'h2222;
        mem_arr[16'h12] = 16'h3333; ref_mem[16'h12] = 16'h3333;
        mem_arr[16'h13] = 16'h4444; ref_mem[16'h13] = 16'h4444;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_readyC", readyC, 0);
        check("rst_readM", readM, 0);
        check("rst_writeM", writeM, 0);
        check("rst_address_M", address_M, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Read miss then hit within the same line.
        do_req(1'b0, 16'h0013, '0);
        check("tp_first_miss_count", miss_count, 16'd1);
        do_req(1'b0, 16'h0011, '0);
        check("tp_first_hit_count", hit_count, 16'd1);

        // Two-way conflict in set 0: 0x0010 becomes LRU and is evicted by 0x0020.
        do_req(1'b0, 16'h0000, '0);
        do_req(1'b0, 16'h0010, '0);
        do_req(1'b0, 16'h0000, '0);
        do_req(1'b0, 16'h0020, '0);
        do_req(1'b0, 16'h0000, '0);
        do_req(1'b0, 16'h0010, '0);

        // Write hit, then read back.
        do_req(1'b1, 16'h0012, 16'hBEEF);
        do_req(1'b0, 16'h0012, '0);

        // Write miss with allocate on a cold cache.
        do_reset();
        do_req(1'b1, 16'h0031, 16'hCAFE);
        check("wmiss_miss_count", miss_count, 16'd1);
        do_req(1'b0, 16'h0031, '0);
        check("wmiss_hit_count", hit_count, 16'd1);

        // Random mixed traffic over a small footprint to force conflicts.
        for (int i = 0; i < 300; i++) begin
            a  = 16'($urandom_range(0, 63));
            d  = 16'($urandom);
            wr = ($urandom_range(0, 9) < 4);
            do_req(wr, a, d);
        end

        // Memory busy: readM must wait for input_readyM.
        block = 1'b1;
        fork
            do_req(1'b0, 16'h0098, '0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("busy_readM_low", readM, 0);
                end
                block = 1'b0;
                @(negedge clk);
                check("busy_readM_rise", readM, 1);
            end
        join

        // Reset in the middle of a fill; the late readyM must be ignored.
        fixed_lat = 4;
        @(posedge clk); #1;
        cur_addr = 16'h0094;
        address  = 16'h0094;
        readC    = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!readM && t < 50);
        check("midfill_readM_seen", readM, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midfill_rst_readM", readM, 0);
        check("midfill_rst_address_M", address_M, 0);
        check("midfill_rst_hit_count", hit_count, 0);
        check("midfill_rst_miss_count", miss_count, 0);
        readC = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("stale_readyM_no_req", readM, 0);
        check("stale_readyM_no_miss", miss_count, 0);
        fixed_lat = 0;
        do_req(1'b0, 16'h0094, '0);
        check("after_rst_miss_count", miss_count, 16'd1);
        do_req(1'b0, 16'h0000, '0);
        check("after_rst_cold_miss", miss_count, 16'd2);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
